// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between icache and dcache.
// Grants one line transfer at a time, inserts a release cycle after every ack, and aborts stalled
// transfers with a watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AddrWidth-1:0] icache2arb_addr_i,
  input  logic [DataWidth-1:0] icache2arb_w_data_i,
  input  logic                 icache2arb_w_en_i,
  input  logic                 icache2arb_req_i,
  output logic [DataWidth-1:0] arb2icache_r_data_o,
  output logic                 arb2icache_ack_o,
  input  logic [AddrWidth-1:0] dcache2arb_addr_i,
  input  logic [DataWidth-1:0] dcache2arb_w_data_i,
  input  logic                 dcache2arb_w_en_i,
  input  logic                 dcache2arb_req_i,
  output logic [DataWidth-1:0] arb2dcache_r_data_o,
  output logic                 arb2dcache_ack_o,
  output logic [AddrWidth-1:0] arb2mem_addr_o,
  output logic [DataWidth-1:0] arb2mem_w_data_o,
  output logic                 arb2mem_w_en_o,
  output logic                 arb2mem_req_o,
  input  logic [DataWidth-1:0] mem2arb_r_data_i,
  input  logic                 mem2arb_ack_i,
  output logic [1:0]           gnt_o,
  output logic                 err_timeout_o
);

  localparam int unsigned WdWidth =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;  // 1 = dcache preferred
  logic [1:0]           gnt_q, gnt_d;
  logic [WdWidth-1:0]   wd_q, wd_d;
  logic                 err_q, err_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 wen_q, wen_d;
  logic                 req_q, req_d;
  logic                 timeout;
  logic                 pick_d;
  logic [DataWidth-1:0] fwd_rdata;

  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == StBusy) &&
                   (32'(wd_q) + 32'd1 == TIMEOUT_CYCLES);

  // A genuine ack in the timeout cycle wins and carries real data.
  assign fwd_rdata = (timeout && !mem2arb_ack_i) ? '0 : mem2arb_r_data_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wd_d    = wd_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    req_d   = req_q;
    pick_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (icache2arb_req_i || dcache2arb_req_i) begin
          pick_d  = (icache2arb_req_i && dcache2arb_req_i) ? ptr_q : dcache2arb_req_i;
          gnt_d   = pick_d ? 2'b10 : 2'b01;
          addr_d  = pick_d ? dcache2arb_addr_i : icache2arb_addr_i;
          wdata_d = pick_d ? dcache2arb_w_data_i : icache2arb_w_data_i;
          wen_d   = pick_d ? dcache2arb_w_en_i : icache2arb_w_en_i;
          req_d   = 1'b1;
          wd_d    = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        wd_d = wd_q + WdWidth'(1);
        if (mem2arb_ack_i || timeout) begin
          ptr_d   = gnt_q[0];
          gnt_d   = 2'b00;
          addr_d  = '0;
          wdata_d = '0;
          wen_d   = 1'b0;
          req_d   = 1'b0;
          if (!mem2arb_ack_i) err_d = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b1;
      gnt_q   <= 2'b00;
      wd_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      req_q   <= req_d;
    end
  end

  // gnt_q is non-zero only in BUSY, so it alone gates the response ports.
  assign arb2icache_r_data_o = gnt_q[0] ? fwd_rdata : '0;
  assign arb2icache_ack_o    = gnt_q[0] & (mem2arb_ack_i | timeout);
  assign arb2dcache_r_data_o = gnt_q[1] ? fwd_rdata : '0;
  assign arb2dcache_ack_o    = gnt_q[1] & (mem2arb_ack_i | timeout);

  assign arb2mem_addr_o   = addr_q;
  assign arb2mem_w_data_o = wdata_q;
  assign arb2mem_w_en_o   = wen_q;
  assign arb2mem_req_o    = req_q;
  assign gnt_o            = gnt_q;
  assign err_timeout_o    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: stub main memory with programmable ack delay, plus a transaction-level
// model (round-robin pointer, line memory, sticky error) predicting every grant and response.
module tb_mem_arbiter;
  localparam int unsigned TO = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [DW-1:0] ic_wdata = '0, dc_wdata = '0;
  logic ic_wen = 1'b0, dc_wen = 1'b0, ic_req = 1'b0, dc_req = 1'b0;
  logic [DW-1:0] ic_rdata, dc_rdata;
  logic ic_ack, dc_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic m_wen, m_req;
  logic [DW-1:0] m_rdata;
  logic m_ack;
  logic [1:0] gnt;
  logic err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache2arb_addr_i   (ic_addr),
    .icache2arb_w_data_i (ic_wdata),
    .icache2arb_w_en_i   (ic_wen),
    .icache2arb_req_i    (ic_req),
    .arb2icache_r_data_o (ic_rdata),
    .arb2icache_ack_o    (ic_ack),
    .dcache2arb_addr_i   (dc_addr),
    .dcache2arb_w_data_i (dc_wdata),
    .dcache2arb_w_en_i   (dc_wen),
    .dcache2arb_req_i    (dc_req),
    .arb2dcache_r_data_o (dc_rdata),
    .arb2dcache_ack_o    (dc_ack),
    .arb2mem_addr_o      (m_addr),
    .arb2mem_w_data_o    (m_wdata),
    .arb2mem_w_en_o      (m_wen),
    .arb2mem_req_o       (m_req),
    .mem2arb_r_data_i    (m_rdata),
    .mem2arb_ack_i       (m_ack),
    .gnt_o               (gnt),
    .err_timeout_o       (err)
  );

  // Stub main memory: acks ack_delay cycles into a request, never when muted.
  bit [DW-1:0] stub_mem [4096];
  int busy_cnt = 0;
  int ack_delay = 5;
  bit mute = 1'b0;
  assign m_ack   = m_req && !mute && (busy_cnt == ack_delay - 1);
  assign m_rdata = stub_mem[m_addr[15:4]];
  always @(posedge clk) begin
    busy_cnt <= m_req ? busy_cnt + 1 : 0;
    if (m_ack && m_wen) stub_mem[m_addr[15:4]] <= m_wdata;
  end

  // Reference model state
  int ptr_m = 1;
  bit err_m = 1'b0;
  logic [DW-1:0] ref_mem [int unsigned];

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    int unsigned k = int'(a[15:4]);
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1;
    err_m = 1'b0;
  endtask

  // Call at a negedge in IDLE with requests already driven; returns at the following IDLE negedge.
  task automatic serve();
    int win, n, exp_lat;
    bit got, to, hold;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, exp_rd;
    logic we;
    win     = (ic_req && dc_req) ? ptr_m : (dc_req ? 1 : 0);
    a       = win ? dc_addr : ic_addr;
    wd      = win ? dc_wdata : ic_wdata;
    we      = win ? dc_wen : ic_wen;
    to      = mute || (ack_delay > int'(TO));
    exp_lat = to ? int'(TO) : ack_delay;
    exp_rd  = to ? '0 : ref_read(a);
    @(negedge clk);
    check("gnt", DW'(gnt), DW'(win ? 2'b10 : 2'b01));
    check("mem_req", DW'(m_req), DW'(1));
    check("mem_addr", DW'(m_addr), DW'(a));
    check("mem_wen", DW'(m_wen), DW'(we));
    if (we) check("mem_wdata", m_wdata, wd);
    n = 1;
    got = 1'b0;
    forever begin
      check("other_ack", DW'(win ? ic_ack : dc_ack), '0);
      if (win ? dc_ack : ic_ack) begin
        got = 1'b1;
        break;
      end
      if (n >= int'(TO) + 2) break;
      @(negedge clk);
      n++;
    end
    check("ack_seen", DW'(got), DW'(1));
    if (got) begin
      check("ack_latency", DW'(n), DW'(exp_lat));
      check("r_data", win ? dc_rdata : ic_rdata, exp_rd);
      check("other_rdata", win ? ic_rdata : dc_rdata, '0);
    end
    ptr_m = win ? 0 : 1;
    if (to) err_m = 1'b1;
    else if (we) ref_mem[int'(a[15:4])] = wd;
    // Sometimes leave req high through RELEASE; it must be absorbed.
    hold = 1'($urandom_range(0, 1));
    if (!hold) begin
      if (win) dc_req = 1'b0;
      else ic_req = 1'b0;
    end
    @(negedge clk);
    check("rel_gnt", DW'(gnt), '0);
    check("rel_mem_req", DW'(m_req), '0);
    check("rel_acks", DW'({ic_ack, dc_ack}), '0);
    check("err_flag", DW'(err), DW'(err_m));
    if (win) dc_req = 1'b0;
    else ic_req = 1'b0;
    @(negedge clk);
    check("idle_gnt", DW'(gnt), '0);
    check("idle_mem_req", DW'(m_req), '0);
  endtask

  task automatic new_ic(input bit wr);
    ic_req   = 1'b1;
    ic_wen   = wr;
    ic_addr  = 32'h1000 * $urandom_range(0, 3);
    ic_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic new_dc(input bit wr);
    dc_req   = 1'b1;
    dc_wen   = wr;
    dc_addr  = 32'h1000 * $urandom_range(0, 3);
    dc_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", DW'(gnt), '0);
    check("rst_mem_req", DW'(m_req), '0);
    check("rst_mem_addr", DW'(m_addr), '0);
    check("rst_mem_wdata", m_wdata, '0);
    check("rst_acks", DW'({ic_ack, dc_ack}), '0);
    check("rst_rdata", ic_rdata | dc_rdata, '0);
    check("rst_err", DW'(err), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone icache read of 0x1000
    ic_req  = 1'b1;
    ic_wen  = 1'b0;
    ic_addr = 32'h1000;
    serve();

    // Simultaneous requests after reset: dcache writes CAFE to 0x2000 first, icache reads it
    do_reset();
    dc_req   = 1'b1;
    dc_wen   = 1'b1;
    dc_addr  = 32'h2000;
    dc_wdata = 128'h0123_4567_89ab_cdef_0000_0000_0000_cafe;
    ic_req   = 1'b1;
    ic_wen   = 1'b0;
    ic_addr  = 32'h2000;
    serve();
    serve();

    // dcache write stream against a persistent icache requester
    for (int i = 0; i < 6; i++) begin
      if (!dc_req) new_dc(1'b1);
      if (!ic_req) new_ic(1'b0);
      serve();
    end
    ic_req = 1'b0;
    dc_req = 1'b0;

    // Randomized traffic with varying memory latency
    for (int i = 0; i < 24; i++) begin
      ack_delay = $urandom_range(1, 7);
      if (!ic_req && $urandom_range(0, 1) == 1) new_ic(1'($urandom_range(0, 1)));
      if (!dc_req && $urandom_range(0, 1) == 1) new_dc(1'($urandom_range(0, 1)));
      if (!ic_req && !dc_req) new_dc(1'($urandom_range(0, 1)));
      serve();
    end
    ic_req = 1'b0;
    dc_req = 1'b0;

    // Ack on the very cycle the watchdog expires: ack wins
    ack_delay = int'(TO);
    new_ic(1'b0);
    serve();
    ack_delay = 5;

    // Reset in the third BUSY cycle
    new_ic(1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", DW'(gnt), '0);
    check("arst_mem_req", DW'(m_req), '0);
    check("arst_ack", DW'({ic_ack, dc_ack}), '0);
    check("arst_rdata", ic_rdata, '0);
    ic_req = 1'b0;
    ptr_m = 1;
    err_m = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("arst_no_ack", DW'({ic_ack, dc_ack}), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    new_ic(1'b0);
    serve();

    // Watchdog abort, then sticky error through a good transfer, then reset clears it
    mute = 1'b1;
    new_dc(1'b0);
    serve();
    mute = 1'b0;
    new_ic(1'b0);
    serve();
    check("err_sticky", DW'(err), DW'(1));
    do_reset();
    @(negedge clk);
    check("err_cleared", DW'(err), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single `type_cache2mem_s` / `type_mem2cache_s` main-memory port between the instruction cache and the data cache. It sits between the two cache miss/writeback interfaces and `main_mem`, and serialises 128-bit line transfers with round-robin fairness. It also enforces the memory's one-request-per-ack protocol by dropping `req` for a release cycle after every ack. A watchdog aborts transfers that never receive an ack.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles in BUSY without ack before abort; 0 disables the watchdog.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `icache2arb_i` in `type_cache2mem_s`: icache request (`addr`, `w_data`, `w_en`, `req`).
- `arb2icache_o` out `type_mem2cache_s`: icache response (`r_data`, `ack`).
- `dcache2arb_i` in `type_cache2mem_s`: dcache request.
- `arb2dcache_o` out `type_mem2cache_s`: dcache response.
- `arb2mem_o` out `type_cache2mem_s`: request to `main_mem`, fully registered.
- `mem2arb_i` in `type_mem2cache_s`: response from `main_mem`.
- `gnt_o` out 2: one-hot current owner, [0]=icache, [1]=dcache; 0 when idle.
- `err_timeout_o` out 1: sticky watchdog flag, cleared only by reset.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any `req` is high, pick the winner and latch its `addr`/`w_data`/`w_en` into `arb2mem_o`. Set `arb2mem_o.req`=1, set `gnt_o`, go to BUSY. With no request, stay in IDLE with `arb2mem_o` = '0.
- Round robin: a 1-bit pointer names the preferred requester and resets to dcache. When both request, the preferred one wins. After any completion, abort included, the pointer moves to the requester that was not just served. A lone requester always wins.
- BUSY: `arb2mem_o` is held constant. The owner's response port equals `mem2arb_i` combinationally. The non-owner's response port is '0. When `mem2arb_i.ack`=1, go to RELEASE.
- RELEASE: lasts exactly one cycle. `arb2mem_o` = '0, `gnt_o`=0, both response ports '0, and requests are ignored. This resets the memory's delay counter and absorbs a requester's `req` that is still high after its ack. Next state is IDLE.
- Watchdog: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle. When it reaches `TIMEOUT_CYCLES` with no ack:
  - drive owner `ack`=1 and `r_data`='0 for that cycle;
  - set `err_timeout_o`;
  - go to RELEASE.
- If ack and the timeout occur in the same cycle, the ack wins: real data is passed and no error is raised.
- Requester contract: `req` and payload stay stable until ack; `req` drops within one cycle after ack. Payload changes during BUSY have no effect.
- `mem2arb_i.ack` arriving in IDLE or RELEASE is ignored and not forwarded.

## Timing
- Reset (async assert): state IDLE, pointer=dcache, `arb2mem_o`='0, both response ports '0, `gnt_o`=0, watchdog=0, `err_timeout_o`=0. Reset asserted mid-transfer aborts immediately with no ack to the requester.
- Request latency: requester `req` seen in IDLE at cycle N; `arb2mem_o.req`=1 from cycle N+1.
- Response latency: 0 cycles. Memory ack in cycle M appears on the owner port in cycle M.
- With the current `main_mem`, ack arrives 5 cycles after `arb2mem_o.req` rises. A single transfer occupies 1 IDLE cycle, 5 BUSY cycles and 1 RELEASE cycle.
- Back-to-back: the next grant decision happens in IDLE, at the earliest 2 cycles after the ack cycle.
- Ack is a one-cycle pulse per transfer on exactly one requester port.

## Test plan
- Reset, then icache read `addr`=0x1000 alone → `arb2mem_o.req` high one cycle later with `addr`=0x1000 and `w_en`=0. `arb2icache_o.ack` pulses 5 cycles later with memory `r_data`. `arb2dcache_o` stays '0 throughout.
- Both request in the same cycle after reset → dcache is served first, then icache. `gnt_o` reads 2'b10, then 0 for RELEASE plus IDLE, then 2'b01.
- dcache issues a stream of writes while icache holds `req` high → grants alternate d, i, d, i with no starvation. Each transfer ends in a RELEASE cycle with `arb2mem_o.req`=0.
- dcache write of `w_data`=128'h…CAFE to 0x2000, then icache read of 0x2000 → icache receives 128'h…CAFE.
- `TIMEOUT_CYCLES`=8 with a stub memory that never acks → owner ack pulses with `r_data`=0 on the 8th BUSY cycle. `err_timeout_o`=1 and stays 1 through later good transfers until `rst_n` is asserted.
- `rst_n` asserted in the 3rd BUSY cycle → all outputs are 0 asynchronously and no ack is seen. After release, a new request gives normal 5-cycle latency to ack.
